dma_burst_engine: RTL
=====================

Name: dma_burst_engine

Overview:
- Sequences transfers between the shared system bus and port B of the 512x32 CI scratch SRAM.
- The CI decoder loads the configuration registers and pulses a start command. The engine then splits the block into bursts, arbitrates for the bus once per burst, moves the data and reports status.
- It is the bus-side datapath controller behind the ramDma custom instruction.

Parameters:
- MEM_AW, 9, SRAM word-address width; addresses wrap modulo 2^MEM_AW.
- BLK_W, 10, block-size counter width, in words.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_bus_addr  in  32  bus byte start address; bits [1:0] ignored, treated as 0.
- cfg_mem_addr  in  MEM_AW  SRAM start word address.
- cfg_block_size  in  BLK_W  total words to move.
- cfg_burst_size  in  8  beats per burst minus 1.
- cmd_start  in  1  one-cycle start pulse.
- cmd_dir  in  2  direction: 01 = bus->SRAM, 10 = SRAM->bus; others invalid.
- status  out  2  [0] busy, [1] error (sticky).
- sram_addr  out  MEM_AW  port-B address.
- sram_we  out  1  port-B write enable.
- sram_wdata  out  32  port-B write data.
- sram_rdata  in  32  port-B read data, valid 1 cycle after sram_addr.
- busOut_request  out  1  bus request.
- busIn_grants  in  1  bus grant.
- busOut_begin_transaction  out  1  begin pulse.
- busOut_address_data  out  32  address during begin, write data during beats.
- busOut_burst_size  out  8  beats minus 1, valid during begin.
- busOut_read_n_write  out  1  1 = read, valid during begin.
- busOut_byte_enable  out  4  4'hF during begin, else 0.
- busOut_data_valid  out  1  write beat valid.
- busOut_end_transaction  out  1  write-burst end pulse.
- busIn_address_data  in  32  read data.
- busIn_data_valid  in  1  read beat valid.
- busIn_end_transaction  in  1  end of read burst.
- busIn_busy  in  1  slave stall for write beats.
- busIn_error  in  1  bus error.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state IDLE; counters 0; status 2'b00.
- States: IDLE, REQ, BEGIN, RD_DATA, WR_DATA, WR_END, DONE_CHK.
- IDLE:
  - cmd_start with a valid cmd_dir latches all cfg_* inputs, clears status[1], sets status[0].
  - A block size of 0 returns to IDLE in the next cycle with busy cleared and no bus activity.
  - A nonzero block size goes to REQ.
  - An invalid cmd_dir sets status[1] and stays in IDLE.
- cmd_start while busy: ignored, configuration unchanged.
- REQ:
  - Hold busOut_request=1.
  - On busIn_grants go to BEGIN.
  - Beats for this burst = min(burst+1, remaining).
- BEGIN (exactly 1 cycle):
  - begin_transaction=1, address_data = current bus address, burst_size = beats-1, read_n_write per direction, byte_enable=4'hF.
  - Go to RD_DATA or WR_DATA.
- RD_DATA:
  - Each busIn_data_valid writes busIn_address_data to the SRAM at the current mem address in the same cycle (sram_we=1).
  - Then mem address +1 (wraps), bus address +4, remaining -1.
  - busIn_end_transaction goes to DONE_CHK. Beats after the planned count are dropped.
- WR_DATA:
  - SRAM word N is prefetched one cycle before it is driven.
  - data_valid=1 with the word on address_data.
  - While busIn_busy=1, hold the same word and data_valid; counters do not advance.
  - After the last beat is accepted (busy=0), go to WR_END.
- WR_END: busOut_end_transaction=1 for 1 cycle, then DONE_CHK.
- busOut_request is held from REQ until the burst ends, then dropped for at least 1 cycle in DONE_CHK. The bus is re-arbitrated per burst.
- DONE_CHK: if remaining=0, clear busy and go to IDLE; else go to REQ.
- busIn_error in any non-IDLE state:
  - Abort and drop request and data_valid.
  - If a write burst is in progress, pulse end_transaction for 1 cycle.
  - Set status[1], clear status[0], go to IDLE. Remaining words are not transferred.
- Bus address increments modulo 2^32.
- Reset mid-transfer: outputs return to 0 immediately (asynchronous); no end_transaction is emitted.

Test Plan:
- Read, bus 0x1000, mem 0, size 8, burst 3: two bursts, begin addresses 0x1000 and 0x1010, burst_size 3 each. SRAM words 0..7 hold the bus data; request dropped between bursts; busy falls after the 2nd end.
- Write, mem 510, size 4, burst 15: one burst, burst_size 3. Words 510, 511, 0, 1 are sent in order; end_transaction pulses once.
- Write with busIn_busy high for 3 cycles on beat 2: beat 2 data is held 4 cycles, no word is skipped or duplicated.
- Read with busIn_error on beat 3 of a size-10 read: request drops the next cycle, status=2'b10, only 2 words written.
- Size 0 with start, and start while busy: no request ever asserted; the busy-time start does not change the configuration.
- Reset low in WR_DATA: all bus outputs 0 asynchronously; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/dma_burst_engine.sv
// rtl/dma_burst_engine.sv - burst DMA sequencer between the system bus and scratch SRAM port B
//
// Purpose:
//   Takes a block configuration from the CI decoder, splits the block into
//   bus bursts, requests the bus once per burst, and moves words between the
//   system bus and SRAM port B (bus->SRAM on reads, SRAM->bus on writes).
//
// Ports:
//   clock, reset               system clock, asynchronous active-low reset
//   cfg_bus_addr               bus byte start address (bits [1:0] ignored)
//   cfg_mem_addr               SRAM start word address
//   cfg_block_size             words to move
//   cfg_burst_size             beats per burst minus one
//   cmd_start, cmd_dir         start pulse, direction (01 bus->SRAM, 10 SRAM->bus)
//   status                     [0] busy, [1] sticky error
//   sram_addr/we/wdata/rdata   SRAM port B, read data valid one cycle after address
//   busOut_*                   bus master outputs (request, begin, address/data, ...)
//   busIn_*                    bus inputs (grant, read data, end, busy stall, error)
module dma_burst_engine #(
  parameter int MEM_AW = 9,
  parameter int BLK_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       cfg_bus_addr,
  input  logic [MEM_AW-1:0] cfg_mem_addr,
  input  logic [BLK_W-1:0]  cfg_block_size,
  input  logic [7:0]        cfg_burst_size,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_dir,
  output logic [1:0]        status,
  output logic [MEM_AW-1:0] sram_addr,
  output logic              sram_we,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              busOut_request,
  input  logic              busIn_grants,
  output logic              busOut_begin_transaction,
  output logic [31:0]       busOut_address_data,
  output logic [7:0]        busOut_burst_size,
  output logic              busOut_read_n_write,
  output logic [3:0]        busOut_byte_enable,
  output logic              busOut_data_valid,
  output logic              busOut_end_transaction,
  input  logic [31:0]       busIn_address_data,
  input  logic              busIn_data_valid,
  input  logic              busIn_end_transaction,
  input  logic              busIn_busy,
  input  logic              busIn_error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_BEGIN    = 3'd2,
    S_RD_DATA  = 3'd3,
    S_WR_DATA  = 3'd4,
    S_WR_END   = 3'd5,
    S_DONE_CHK = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         bus_addr_q, bus_addr_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]    remaining_q, remaining_d;
  logic [BLK_W-1:0]    beats_q, beats_d;     // beats left in the current burst
  logic [7:0]          burst_q, burst_d;
  logic                rd_dir_q, rd_dir_d;   // 1: bus->SRAM (bus read)
  logic                err_q, err_d;

  logic [BLK_W-1:0]    burst_beats;
  logic                wr_burst;

  assign burst_beats = BLK_W'(burst_q) + BLK_W'(1);
  assign wr_burst    = (state_q == S_WR_DATA) || (state_q == S_WR_END);
  assign status      = {err_q, state_q != S_IDLE};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bus_addr_q  <= '0;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      burst_q     <= '0;
      rd_dir_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      burst_q     <= burst_d;
      rd_dir_q    <= rd_dir_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    burst_d     = burst_q;
    rd_dir_d    = rd_dir_q;
    err_d       = err_q;

    sram_addr                = '0;
    sram_we                  = 1'b0;
    sram_wdata               = '0;
    busOut_request           = 1'b0;
    busOut_begin_transaction = 1'b0;
    busOut_address_data      = '0;
    busOut_burst_size        = '0;
    busOut_read_n_write      = 1'b0;
    busOut_byte_enable       = '0;
    busOut_data_valid        = 1'b0;
    busOut_end_transaction   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          if (cmd_dir == 2'b01 || cmd_dir == 2'b10) begin
            bus_addr_d  = cfg_bus_addr & 32'hFFFF_FFFC;
            mem_addr_d  = cfg_mem_addr;
            remaining_d = cfg_block_size;
            burst_d     = cfg_burst_size;
            rd_dir_d    = (cmd_dir == 2'b01);
            err_d       = 1'b0;
            // An empty block still shows busy for one cycle via DONE_CHK.
            state_d     = (cfg_block_size == '0) ? S_DONE_CHK : S_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        busOut_request = 1'b1;
        beats_d = (remaining_q < burst_beats) ? remaining_q : burst_beats;
        if (busIn_grants) state_d = S_BEGIN;
      end

      S_BEGIN: begin
        busOut_request           = 1'b1;
        busOut_begin_transaction = 1'b1;
        busOut_address_data      = bus_addr_q;
        busOut_burst_size        = 8'(beats_q - BLK_W'(1));
        busOut_read_n_write      = rd_dir_q;
        busOut_byte_enable       = 4'hF;
        // Prefetch the first write word so it is on rdata in WR_DATA.
        if (!rd_dir_q) sram_addr = mem_addr_q;
        state_d = rd_dir_q ? S_RD_DATA : S_WR_DATA;
      end

      S_RD_DATA: begin
        busOut_request = 1'b1;
        sram_addr      = mem_addr_q;
        // Beats beyond the planned count are dropped.
        if (busIn_data_valid && beats_q != '0) begin
          sram_we     = 1'b1;
          sram_wdata  = busIn_address_data;
          mem_addr_d  = mem_addr_q + MEM_AW'(1);
          bus_addr_d  = bus_addr_q + 32'd4;
          remaining_d = remaining_q - BLK_W'(1);
          beats_d     = beats_q - BLK_W'(1);
        end
        if (busIn_end_transaction) state_d = S_DONE_CHK;
      end

      S_WR_DATA: begin
        busOut_request      = 1'b1;
        busOut_data_valid   = 1'b1;
        busOut_address_data = sram_rdata;
        if (busIn_busy) begin
          // Re-read the same word so rdata stays stable through the stall.
          sram_addr = mem_addr_q;
        end else begin
          sram_addr   = mem_addr_q + MEM_AW'(1);
          mem_addr_d  = mem_addr_q + MEM_AW'(1);
          bus_addr_d  = bus_addr_q + 32'd4;
          remaining_d = remaining_q - BLK_W'(1);
          beats_d     = beats_q - BLK_W'(1);
          if (beats_q == BLK_W'(1)) state_d = S_WR_END;
        end
      end

      S_WR_END: begin
        busOut_request         = 1'b1;
        busOut_end_transaction = 1'b1;
        state_d                = S_DONE_CHK;
      end

      S_DONE_CHK: begin
        state_d = (remaining_q == '0) ? S_IDLE : S_REQ;
      end

      default: state_d = S_IDLE;
    endcase

    // Bus error aborts whatever is in flight; an open write burst is closed.
    if (state_q != S_IDLE && busIn_error) begin
      state_d                = S_IDLE;
      err_d                  = 1'b1;
      busOut_request         = 1'b0;
      busOut_data_valid      = 1'b0;
      sram_we                = 1'b0;
      busOut_end_transaction = wr_burst;
    end
  end

endmodule
